// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared dual 1-of-4 mux: drives SEL/EN, returns a one-hot grant,
// time-boxes contended grants to HOLD cycles and inserts one EN-low gap between owners.
module mux4_rr_arbiter #(
    parameter int HOLD = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [0:3] req_i,
    output logic [0:1] sel_o,
    output logic       en_o,
    output logic [0:3] gnt_o,
    output logic       busy_o
);
    localparam int CW = $clog2(HOLD) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0] cand [4];
    logic [3:0] cand_req;
    logic [3:0] other_req;
    logic [1:0] win;
    logic       win_valid;
    logic       others;
    logic [0:3] gnt_d;

    // Candidate k is LAST+k+1 mod 4, so the previous owner is always examined last.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi]      = last_q + 2'(gi + 1);
            assign cand_req[gi]  = req_i[cand[gi]];
            assign other_req[gi] = req_i[gi] && (owner_q != 2'(gi));
            assign gnt_d[gi]     = (state_d == S_GRANT) && (owner_d == 2'(gi));
        end
    endgenerate

    assign win_valid = |cand_req;
    assign others    = |other_req;

    always_comb begin
        win = cand[3];
        for (int k = 3; k >= 0; k--) begin
            if (cand_req[k]) begin
                win = cand[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_GRANT: begin
                if (!req_i[owner_q]) begin
                    state_d = S_GAP;
                end else if ((cnt_q == CNT_MAX) && others) begin
                    state_d = S_GAP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE and GAP both arbitrate; owner is kept on a miss so SEL stays quiet.
                if (win_valid) begin
                    state_d = S_GRANT;
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            sel_o   <= 2'b00;
            en_o    <= 1'b0;
            gnt_o   <= 4'b0000;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_o   <= owner_d;
            en_o    <= (state_d == S_GRANT);
            gnt_o   <= gnt_d;
            busy_o  <= (state_d != S_IDLE);
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: three instances (HOLD 4, 8, 1) share stimulus and are checked
// every cycle against a cycle-counting behavioural model, plus directed literal expectations.
module tb_mux4_rr_arbiter;
    localparam int HV [3] = '{4, 8, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:3] req = 4'b0000;

    logic [0:1] sel_w  [3];
    logic       en_w   [3];
    logic [0:3] gnt_w  [3];
    logic       busy_w [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mux4_rr_arbiter #(.HOLD(HV[gi])) u_dut (
                .clk_i (clk),
                .rst_i (rst),
                .req_i (req),
                .sel_o (sel_w[gi]),
                .en_o  (en_w[gi]),
                .gnt_o (gnt_w[gi]),
                .busy_o(busy_w[gi])
            );
        end
    endgenerate

    // Model: owner (-1 = nobody), gap flag, selected source, last owner, EN cycles already served.
    int m_own  [3];
    int m_sel  [3];
    int m_last [3];
    int m_held [3];
    bit m_gap  [3];

    always @(posedge clk or posedge rst) begin
        int o, s, l, h, c;
        bit g, others, found;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                o = -1; s = 0; l = 3; h = 0; g = 1'b0;
            end else begin
                o = m_own[k]; s = m_sel[k]; l = m_last[k]; h = m_held[k]; g = m_gap[k];
                if (o >= 0 && !g) begin
                    others = 1'b0;
                    for (int j = 0; j < 4; j++) if (j != o && req[j]) others = 1'b1;
                    if (!req[o] || (h >= HV[k] && others)) g = 1'b1;
                    else h = h + 1;
                end else begin
                    found = 1'b0;
                    for (int j = 1; j <= 4; j++) begin
                        c = (l + j) % 4;
                        if (!found && req[c]) begin
                            found = 1'b1;
                            o = c; s = c; l = c; h = 1; g = 1'b0;
                        end
                    end
                    if (!found) begin
                        o = -1; g = 1'b0;
                    end
                end
            end
            m_own[k]  <= o;
            m_sel[k]  <= s;
            m_last[k] <= l;
            m_held[k] <= h;
            m_gap[k]  <= g;
        end
    end

    always @(negedge clk) begin
        logic       e_en, e_busy;
        logic [0:3] e_gnt;
        for (int k = 0; k < 3; k++) begin
            e_en   = (m_own[k] >= 0) && !m_gap[k];
            e_busy = (m_own[k] >= 0);
            e_gnt  = 4'b0000;
            if (e_en) e_gnt[m_own[k]] = 1'b1;
            n_tests++;
            if (en_w[k] !== e_en || busy_w[k] !== e_busy || gnt_w[k] !== e_gnt ||
                int'(sel_w[k]) != m_sel[k]) begin
                n_fail++;
                $display("FAIL model[H=%0d] t=%0t: got sel=%b en=%b gnt=%b busy=%b want sel=%0d en=%b gnt=%b busy=%b",
                         HV[k], $time, sel_w[k], en_w[k], gnt_w[k], busy_w[k],
                         m_sel[k], e_en, e_gnt, e_busy);
            end
            n_tests++;
            if ($countones(gnt_w[k]) > 1) begin
                n_fail++;
                $display("FAIL onehot[H=%0d] t=%0t: got gnt=%b want at most one bit", HV[k], $time, gnt_w[k]);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h want %0h", nm, $time, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", nm, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int p, o;
        logic [0:3] eg;
        step(3);
        rst = 1'b0;
        step(1);
        chk("idle_busy", busy_w[0], 0);
        chk("idle_gnt", gnt_w[0], 4'b0000);

        // Single requester keeps the grant indefinitely.
        req = 4'b0010;
        step(1);
        chk("single_gnt", gnt_w[0], 4'b0010);
        chk("single_sel", sel_w[0], 2'b10);
        chk("single_en", en_w[0], 1);
        step(50);
        chk("single_hold_gnt_h1", gnt_w[2], 4'b0010);
        req = 4'b0000;
        step(1);
        chk("release_en", en_w[0], 0);
        chk("release_busy_gap", busy_w[0], 1);
        step(1);
        chk("release_idle_busy", busy_w[0], 0);

        // Sub-cycle pulse between edges is invisible.
        req = 4'b0010;
        #3;
        req = 4'b0000;
        step(1);
        chk("glitch_ignored_busy", busy_w[0], 0);

        // Asynchronous reset mid-grant, then full contention.
        req = 4'b1111;
        step(3);
        rst = 1'b1;
        #1;
        chk("rst_sel", sel_w[0], 2'b00);
        chk("rst_en", en_w[0], 0);
        chk("rst_gnt", gnt_w[0], 4'b0000);
        chk("rst_busy", busy_w[0], 0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("post_rst_gnt_h8", gnt_w[1], 4'b1000);
        for (int c = 1; c <= 21; c++) begin
            p  = (c - 1) % 5;
            o  = ((c - 1) / 5) % 4;
            eg = 4'b0000;
            if (p != 4) eg[o] = 1'b1;
            chk($sformatf("rr4_c%0d_gnt", c), gnt_w[0], eg);
            chk($sformatf("rr4_c%0d_sel", c), sel_w[0], o);
            step(1);
        end

        // Early release by owner 1 while 3 waits (HOLD=8).
        do_reset();
        req = 4'b0100;
        step(1);
        chk("early_gnt1", gnt_w[1], 4'b0100);
        req = 4'b0101;
        step(2);
        req = 4'b0001;
        step(1);
        chk("early_gap_en", en_w[1], 0);
        chk("early_gap_sel", sel_w[1], 2'b01);
        step(1);
        chk("early_gnt3", gnt_w[1], 4'b0001);
        req = 4'b1010;
        step(2);
        chk("after3_gnt0", gnt_w[1], 4'b1000);

        // Late arrival preempts a saturated owner (HOLD=8).
        do_reset();
        req = 4'b1000;
        step(1);
        chk("late_gnt0", gnt_w[1], 4'b1000);
        step(19);
        req = 4'b1010;
        step(1);
        chk("late_preempt_en", en_w[1], 0);
        step(1);
        chk("late_gnt2_first", gnt_w[1], 4'b0010);
        step(7);
        chk("late_gnt2_last", gnt_w[1], 4'b0010);
        step(1);
        chk("late_gap_en", en_w[1], 0);
        step(1);
        chk("late_back_gnt0", gnt_w[1], 4'b1000);

        // HOLD=1 alternation between requesters 1 and 3.
        do_reset();
        req = 4'b0101;
        step(1);
        chk("h1_gnt1", gnt_w[2], 4'b0100);
        step(1);
        chk("h1_gap_en", en_w[2], 0);
        chk("h1_gap_sel", sel_w[2], 2'b01);
        step(1);
        chk("h1_gnt3", gnt_w[2], 4'b0001);
        step(1);
        chk("h1_gap2_sel", sel_w[2], 2'b11);
        step(1);
        chk("h1_gnt1_again", gnt_w[2], 4'b0100);

        req = 4'b0000;
        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
